// File: rtl/clct_peak_pkg.sv
// Shared widths, FSM encoding and hold-register bundle for clct_peak_hold.
// The subkey field exists only when CLCT_PEAK_SUBKEY_EN is defined.
package clct_peak_pkg;

    localparam int MXPATB     = 7;
    localparam int MXKEYBX    = 8;
    localparam int MXQLTB     = 6;
    localparam int MXBNDB     = 5;
    localparam int MXPATC     = 12;
    localparam int MXSUBKEYBX = 10;
    localparam int MXDLYB     = 3;
    localparam int MXSKEYB    = 6;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_EMIT  = 2'd2,
        S_DEAD  = 2'd3
    } state_t;

    typedef struct packed {
        logic [MXPATB-1:0]     pat;
        logic [MXKEYBX-1:0]    key;
        logic [MXBNDB-1:0]     bend;
        logic [MXPATC-1:0]     carry;
`ifdef CLCT_PEAK_SUBKEY_EN
        logic [MXSUBKEYBX-1:0] subkey;
`endif
        logic [MXQLTB-1:0]     qlt;
    } hold_t;

endpackage

// File: rtl/clct_peak_hold_sat_cnt8.sv
// 8-bit saturating event counter with synchronous clear.
// Clear wins over an increment in the same cycle.
module sat_cnt8 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_clr,
    input  logic       i_inc,
    output logic [7:0] o_cnt
);

    logic [7:0] r_cnt;

    // Count up, stick at 255, clear on request
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= 8'd0;
        end else if (i_clr) begin
            r_cnt <= 8'd0;
        end else if (i_inc && (r_cnt != 8'hFF)) begin
            r_cnt <= r_cnt + 8'd1;
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/clct_peak_hold.sv
// Peak-hold of the best CLCT candidate over a drift window, with dead time.
// Optional macro CLCT_PEAK_SUBKEY_EN: carry the quarter-strip key through.
module clct_peak_hold
    import clct_peak_pkg::*;
#(
    parameter int PATLUT = 0
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic [MXPATB-1:0]     pat_in,
    input  logic [MXKEYBX-1:0]    key_in,
    input  logic [MXBNDB-1:0]     bend_in,
    input  logic [MXPATC-1:0]     carry_in,
    input  logic [MXSUBKEYBX-1:0] subkey_in,
    input  logic [MXQLTB-1:0]     qlt_in,
    input  logic                  enable,
    input  logic [2:0]            nhit_thresh,
    input  logic [3:0]            pid_thresh,
    input  logic [MXDLYB-1:0]     drift_dly,
    input  logic [MXDLYB-1:0]     dead_time,
    input  logic                  clr_lost,
    output logic                  clct_vld,
    output logic [MXPATB-1:0]     clct_pat,
    output logic [MXKEYBX-1:0]    clct_key,
    output logic [MXBNDB-1:0]     clct_bend,
    output logic [MXPATC-1:0]     clct_carry,
    output logic [MXSUBKEYBX-1:0] clct_subkey,
    output logic [MXQLTB-1:0]     clct_qlt,
    output logic                  busy,
    output logic [7:0]            lost_cnt
);

    hold_t               r_s0;
    hold_t               r_hold;
    hold_t               r_out;
    hold_t               w_in;
    hold_t               w_out;
    state_t              r_state;
    state_t              w_state_nxt;
    logic [MXDLYB-1:0]   r_cnt;
    logic [MXDLYB-1:0]   r_dt;
    logic [MXDLYB-1:0]   w_cnt_nxt;
    logic [MXDLYB-1:0]   w_dt_nxt;
    logic                w_pass;
    logic                w_load;
    logic                w_inc;
    logic [MXSKEYB-1:0]  w_skey_s0;
    logic [MXSKEYB-1:0]  w_skey_hold;

    assign w_in.pat    = pat_in;
    assign w_in.key    = key_in;
    assign w_in.bend   = bend_in;
    assign w_in.carry  = carry_in;
    assign w_in.qlt    = qlt_in;
`ifdef CLCT_PEAK_SUBKEY_EN
    assign w_in.subkey = subkey_in;
`else
    logic w_unused_subkey;
    assign w_unused_subkey = ^subkey_in;
`endif

    // Stage 0: register the sorter winner every bx
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_s0 <= '0;
        end else begin
            r_s0 <= w_in;
        end
    end

    assign w_pass = enable
                  & (r_s0.pat[6:4] >= nhit_thresh)
                  & (r_s0.pat[3:0] >= pid_thresh);

    assign w_skey_s0   = (PATLUT != 0) ? r_s0.qlt
                                       : r_s0.pat[MXPATB-1:1];
    assign w_skey_hold = (PATLUT != 0) ? r_hold.qlt
                                       : r_hold.pat[MXPATB-1:1];

    // FSM state and window/dead-time counters
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_dt    <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_dt    <= w_dt_nxt;
        end
    end

    // Next state, hold-load strobe and lost-trigger strobe
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_dt_nxt    = r_dt;
        w_load      = 1'b0;
        w_inc       = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (w_pass) begin
                    w_load    = 1'b1;
                    w_cnt_nxt = drift_dly;
                    w_dt_nxt  = dead_time;
                    if (drift_dly == '0) begin
                        w_state_nxt = S_EMIT;
                    end else begin
                        w_state_nxt = S_ACCUM;
                    end
                end
            end
            S_ACCUM: begin
                if (!enable) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    if (w_pass && (w_skey_s0 > w_skey_hold)) begin
                        w_load = 1'b1;
                    end
                    if (r_cnt <= MXDLYB'(1)) begin
                        w_state_nxt = S_EMIT;
                    end else begin
                        w_cnt_nxt = r_cnt - MXDLYB'(1);
                    end
                end
            end
            S_EMIT: begin
                if (r_dt == '0) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_state_nxt = S_DEAD;
                end
            end
            S_DEAD: begin
                w_inc = w_pass;
                if (r_dt <= MXDLYB'(1)) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_dt_nxt = r_dt - MXDLYB'(1);
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Best-candidate hold registers
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_hold <= '0;
        end else if (w_load) begin
            r_hold <= r_s0;
        end
    end

    // Output fields keep the last emitted candidate
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_out <= '0;
        end else if (r_state == S_EMIT) begin
            r_out <= r_hold;
        end
    end

    assign w_out    = (r_state == S_EMIT) ? r_hold : r_out;
    assign clct_vld = (r_state == S_EMIT);
    assign busy     = (r_state != S_IDLE);

    assign clct_pat    = w_out.pat;
    assign clct_key    = w_out.key;
    assign clct_bend   = w_out.bend;
    assign clct_carry  = w_out.carry;
    assign clct_qlt    = w_out.qlt;
`ifdef CLCT_PEAK_SUBKEY_EN
    assign clct_subkey = w_out.subkey;
`else
    assign clct_subkey = {w_out.key, 2'b00};
`endif

    sat_cnt8 u_lost (
        .clk   (clock),
        .rst_n (reset_n),
        .i_clr (clr_lost),
        .i_inc (w_inc),
        .o_cnt (lost_cnt)
    );

endmodule

// File: tb/tb_clct_peak_hold.sv
// Directed self-checking bench for clct_peak_hold.
// Inputs change 1ns after the rising edge; outputs are checked there too.
module tb_clct_peak_hold;

    logic        clock;
    logic        reset_n;
    logic [6:0]  pat_in;
    logic [7:0]  key_in;
    logic [4:0]  bend_in;
    logic [11:0] carry_in;
    logic [9:0]  subkey_in;
    logic [5:0]  qlt_in;
    logic        enable;
    logic [2:0]  nhit_thresh;
    logic [3:0]  pid_thresh;
    logic [2:0]  drift_dly;
    logic [2:0]  dead_time;
    logic        clr_lost;
    logic        clct_vld;
    logic [6:0]  clct_pat;
    logic [7:0]  clct_key;
    logic [4:0]  clct_bend;
    logic [11:0] clct_carry;
    logic [9:0]  clct_subkey;
    logic [5:0]  clct_qlt;
    logic        busy;
    logic [7:0]  lost_cnt;

    int n_chk;
    int n_fail;

    clct_peak_hold #(.PATLUT(0)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .pat_in      (pat_in),
        .key_in      (key_in),
        .bend_in     (bend_in),
        .carry_in    (carry_in),
        .subkey_in   (subkey_in),
        .qlt_in      (qlt_in),
        .enable      (enable),
        .nhit_thresh (nhit_thresh),
        .pid_thresh  (pid_thresh),
        .drift_dly   (drift_dly),
        .dead_time   (dead_time),
        .clr_lost    (clr_lost),
        .clct_vld    (clct_vld),
        .clct_pat    (clct_pat),
        .clct_key    (clct_key),
        .clct_bend   (clct_bend),
        .clct_carry  (clct_carry),
        .clct_subkey (clct_subkey),
        .clct_qlt    (clct_qlt),
        .busy        (busy),
        .lost_cnt    (lost_cnt)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic [6:0] p, input logic [7:0] k);
        pat_in    = p;
        key_in    = k;
        subkey_in = {k, 2'b00};
        bend_in   = k[4:0];
        carry_in  = {4'h0, k};
        qlt_in    = k[5:0];
    endtask

    int seen;

    initial begin
        n_chk       = 0;
        n_fail      = 0;
        reset_n     = 1'b0;
        enable      = 1'b1;
        nhit_thresh = 3'd1;
        pid_thresh  = 4'd0;
        drift_dly   = 3'd0;
        dead_time   = 3'd0;
        clr_lost    = 1'b0;
        drive(7'h00, 8'd0);
        step();
        step();
        chk("rst_vld", clct_vld, 0);
        chk("rst_busy", busy, 0);
        chk("rst_key", clct_key, 0);
        chk("rst_lost", lost_cnt, 0);
        reset_n = 1'b1;
        step();

        // Single hit, no drift, no dead time
        drive(7'b1100101, 8'd37);
        step();
        drive(7'h00, 8'd0);
        chk("t1_vld_early", clct_vld, 0);
        step();
        chk("t1_vld", clct_vld, 1);
        chk("t1_key", clct_key, 37);
        chk("t1_pat", clct_pat, 32'h65);
        chk("t1_subkey", clct_subkey, 148);
        chk("t1_busy_emit", busy, 1);
        step();
        chk("t1_vld_once", clct_vld, 0);
        chk("t1_busy_low", busy, 0);
        step();
        chk("t1_key_held", clct_key, 37);

        // Drift window of 3 samples: best is the middle one
        drift_dly = 3'd2;
        drive(7'h43, 8'd50);
        step();
        drive(7'h64, 8'd51);
        chk("t2_vld_c1", clct_vld, 0);
        step();
        drive(7'h52, 8'd52);
        chk("t2_vld_c2", clct_vld, 0);
        step();
        drive(7'h00, 8'd0);
        chk("t2_vld_c3", clct_vld, 0);
        step();
        chk("t2_vld", clct_vld, 1);
        chk("t2_key", clct_key, 51);
        chk("t2_pat", clct_pat, 32'h64);
        step();
        chk("t2_vld_once", clct_vld, 0);
        chk("t2_busy_low", busy, 0);

        // Equal sort keys: earlier candidate wins
        drive(7'h65, 8'd10);
        step();
        drive(7'h65, 8'd11);
        step();
        drive(7'h00, 8'd0);
        step();
        step();
        chk("t3_vld", clct_vld, 1);
        chk("t3_key", clct_key, 10);
        step();

        // Dead time of 3: three passing bx dropped and counted
        drift_dly = 3'd0;
        dead_time = 3'd3;
        drive(7'h65, 8'd20);
        step();
        drive(7'h00, 8'd0);
        step();
        chk("t4_vld", clct_vld, 1);
        chk("t4_key", clct_key, 20);
        drive(7'h65, 8'd99);
        seen = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (i == 2) drive(7'h00, 8'd0);
            if (clct_vld) seen++;
        end
        chk("t4_no_capture", seen, 0);
        chk("t4_lost", lost_cnt, 3);
        chk("t4_busy_low", busy, 0);
        chk("t4_key_held", clct_key, 20);
        step();
        chk("t4_idle_vld", clct_vld, 0);

        // Continuous passes with dead time 7 drive lost_cnt into saturation
        dead_time = 3'd7;
        drive(7'h65, 8'd99);
        for (int i = 0; i < 400; i++) step();
        seen = 0;
        for (int i = 0; i < 20 && !clct_vld; i++) step();
        chk("sat_vld_seen", clct_vld, 1);
        chk("sat_lost", lost_cnt, 255);
        chk("sat_key", clct_key, 99);
        step();
        chk("sat_in_dead", busy, 1);
        clr_lost = 1'b1;
        step();
        clr_lost = 1'b0;
        chk("clr_priority", lost_cnt, 0);
        step();
        chk("clr_then_inc", lost_cnt, 1);
        drive(7'h00, 8'd0);
        for (int i = 0; i < 12 && busy; i++) step();
        chk("sat_idle", busy, 0);
        clr_lost = 1'b1;
        step();
        clr_lost = 1'b0;
        chk("clr_lost", lost_cnt, 0);

        // Hit-count threshold blocks a 3-hit pattern
        dead_time   = 3'd0;
        nhit_thresh = 3'd4;
        drive(7'h35, 8'd5);
        step();
        drive(7'h00, 8'd0);
        seen = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            if (busy) seen++;
        end
        chk("thr_nhit", seen, 0);

        // Pattern-ID threshold blocks id 5
        nhit_thresh = 3'd1;
        pid_thresh  = 4'd6;
        drive(7'h65, 8'd6);
        step();
        drive(7'h00, 8'd0);
        seen = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            if (busy) seen++;
        end
        chk("thr_pid", seen, 0);
        pid_thresh = 4'd0;

        // Enable dropped inside the window aborts without an emit
        drift_dly = 3'd3;
        drive(7'h65, 8'd70);
        step();
        drive(7'h00, 8'd0);
        step();
        chk("ab_accum", busy, 1);
        enable = 1'b0;
        step();
        chk("ab_idle", busy, 0);
        enable = 1'b1;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (clct_vld) seen++;
        end
        chk("ab_no_vld", seen, 0);
        chk("ab_key_held", clct_key, 99);

        // Asynchronous reset in the middle of a window
        drive(7'h65, 8'd80);
        step();
        drive(7'h00, 8'd0);
        step();
        chk("rs_accum", busy, 1);
        chk("rs_lost_before", lost_cnt, 0);
        #2;
        reset_n = 1'b0;
        #1;
        chk("rs_vld", clct_vld, 0);
        chk("rs_busy", busy, 0);
        chk("rs_key", clct_key, 0);
        chk("rs_pat", clct_pat, 0);
        #2;
        reset_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (clct_vld || busy) seen++;
        end
        chk("rs_no_emit", seen, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
